// File: rtl/cmul_seq_ctrl.sv
// Complex multiplier sequencer: drives one external WxW unsigned multiplier over four cycles.
// Optional macro CMUL_CONJ_EN adds a conj input selecting A*conj(B).
module cmul_seq_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [W-1:0]      ar_i,
    input  logic [W-1:0]      ai_i,
    input  logic [W-1:0]      br_i,
    input  logic [W-1:0]      bi_i,
`ifdef CMUL_CONJ_EN
    input  logic              conj_i,
`endif
    output logic [W-1:0]      mul_a_o,
    output logic [W-1:0]      mul_b_o,
    input  logic [2*W-1:0]    mul_p_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [2*W+1:0]    re_o,
    output logic [2*W+1:0]    im_o
);

    localparam int unsigned OW = 2 * W + 2;

    typedef enum logic [2:0] {
        StIdle,
        StP0,
        StP1,
        StP2,
        StP3,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    ar_q, ai_q, br_q, bi_q;
    logic [OW-1:0]   re_acc_q, re_acc_d;
    logic [OW-1:0]   im_acc_q, im_acc_d;
    logic [OW-1:0]   re_q, re_d;
    logic [OW-1:0]   im_q, im_d;
    logic [OW-1:0]   prod_ext;
    logic            capture;
    logic            conj_s;

`ifdef CMUL_CONJ_EN
    logic conj_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conj_q <= 1'b0;
        end else if (capture) begin
            conj_q <= conj_i;
        end
    end

    assign conj_s = conj_q;
`else
    assign conj_s = 1'b0;
`endif

    assign prod_ext = {2'b00, mul_p_i};

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        mul_a_o     = '0;
        mul_b_o     = '0;
        re_acc_d    = re_acc_q;
        im_acc_d    = im_acc_q;
        re_d        = re_q;
        im_d        = im_q;

        unique case (state_q)
            StIdle: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    capture = 1'b1;
                    state_d = StP0;
                end
            end
            StP0: begin
                mul_a_o  = ar_q;
                mul_b_o  = br_q;
                re_acc_d = prod_ext;
                state_d  = StP1;
            end
            StP1: begin
                mul_a_o  = ai_q;
                mul_b_o  = bi_q;
                re_acc_d = conj_s ? re_acc_q + prod_ext : re_acc_q - prod_ext;
                state_d  = StP2;
            end
            StP2: begin
                mul_a_o  = ar_q;
                mul_b_o  = bi_q;
                im_acc_d = conj_s ? -prod_ext : prod_ext;
                state_d  = StP3;
            end
            StP3: begin
                mul_a_o  = ai_q;
                mul_b_o  = br_q;
                im_acc_d = im_acc_q + prod_ext;
                // Result registers load here so re/im stay stable through DONE and IDLE.
                re_d     = re_acc_q;
                im_d     = im_acc_q + prod_ext;
                state_d  = StDone;
            end
            StDone: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    in_ready_o = 1'b1;
                    capture    = in_valid_i;
                    state_d    = in_valid_i ? StP0 : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ar_q     <= '0;
            ai_q     <= '0;
            br_q     <= '0;
            bi_q     <= '0;
            re_acc_q <= '0;
            im_acc_q <= '0;
            re_q     <= '0;
            im_q     <= '0;
        end else begin
            state_q  <= state_d;
            re_acc_q <= re_acc_d;
            im_acc_q <= im_acc_d;
            re_q     <= re_d;
            im_q     <= im_d;
            if (capture) begin
                ar_q <= ar_i;
                ai_q <= ai_i;
                br_q <= br_i;
                bi_q <= bi_i;
            end
        end
    end

    assign re_o = re_q;
    assign im_o = im_q;

endmodule

// File: tb/tb_cmul_seq_ctrl.sv
// Self-checking bench for cmul_seq_ctrl (W=4) with a behavioural external multiplier.
// Build with CMUL_CONJ_EN defined to exercise the conjugate mode as well.
module tb_cmul_seq_ctrl;

    localparam int W  = 4;
    localparam int OW = 2 * W + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  ar, ai, br, bi;
    logic          conj;
    logic [W-1:0]  mul_a, mul_b;
    logic [2*W-1:0] mul_p;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] re, im;

    always #5 clk = ~clk;

    // External combinational multiplier.
    assign mul_p = {4'b0000, mul_a} * {4'b0000, mul_b};

    cmul_seq_ctrl #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .ar_i        (ar),
        .ai_i        (ai),
        .br_i        (br),
        .bi_i        (bi),
`ifdef CMUL_CONJ_EN
        .conj_i      (conj),
`endif
        .mul_a_o     (mul_a),
        .mul_b_o     (mul_b),
        .mul_p_i     (mul_p),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .re_o        (re),
        .im_o        (im)
    );

    typedef struct {
        logic [3:0] ar, ai, br, bi;
        logic       conj;
        int         re, im;
    } vec_t;

    vec_t vecs[$];
    int   exp_re_q[$];
    int   exp_im_q[$];
    int   cur_re, cur_im;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   n_results = 0;
    logic prev_ov = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pushes on accept, pops and compares on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (out_valid && !prev_ov) check("latency", cyc - acc_cyc, 5);
                if (out_valid && out_ready) begin
                    check("sb_nonempty", int'(exp_re_q.size() > 0), 1);
                    if (exp_re_q.size() > 0) begin
                        check("re", int'($signed(re)), exp_re_q.pop_front());
                        check("im", int'($signed(im)), exp_im_q.pop_front());
                        n_results++;
                    end
                end
                if (in_valid && in_ready) begin
                    exp_re_q.push_back(cur_re);
                    exp_im_q.push_back(cur_im);
                    acc_cyc = cyc;
                end
                prev_ov = out_valid;
            end else begin
                prev_ov = 1'b0;
            end
            cyc++;
        end
    end

    function automatic vec_t mk(input logic [3:0] a_r, input logic [3:0] a_i,
                                input logic [3:0] b_r, input logic [3:0] b_i,
                                input logic cj, input int e_re, input int e_im);
        vec_t v;
        v.ar = a_r; v.ai = a_i; v.br = b_r; v.bi = b_i;
        v.conj = cj; v.re = e_re; v.im = e_im;
        return v;
    endfunction

    // Drive a vector and return at posedge+1 after it has been accepted.
    task automatic send(input vec_t v, input bit hold);
        int n = 0;
        ar = v.ar; ai = v.ai; br = v.br; bi = v.bi; conj = v.conj;
        cur_re = v.re; cur_im = v.im;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no in_ready, expected within 50 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_out();
        int n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL out_timeout: got no out_valid, expected within 50 cycles");
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; conj = 1'b0;
        ar = '0; ai = '0; br = '0; bi = '0;
        cur_re = 0; cur_im = 0;

        vecs.push_back(mk(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 0, 450));
        vecs.push_back(mk(4'd0, 4'd15, 4'd0, 4'd15, 1'b0, -225, 0));
        vecs.push_back(mk(4'd1, 4'd0, 4'd1, 4'd0, 1'b0, 1, 0));
        vecs.push_back(mk(4'd0, 4'd1, 4'd0, 4'd1, 1'b0, -1, 0));
        vecs.push_back(mk(4'd7, 4'd9, 4'd4, 4'd11, 1'b0, -71, 113));
        vecs.push_back(mk(4'd15, 4'd0, 4'd0, 4'd15, 1'b0, 0, 225));
        vecs.push_back(mk(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 0, 0));
`ifdef CMUL_CONJ_EN
        vecs.push_back(mk(4'd3, 4'd2, 4'd5, 4'd4, 1'b1, 23, -2));
        vecs.push_back(mk(4'd3, 4'd2, 4'd5, 4'd4, 1'b0, 7, 22));
        vecs.push_back(mk(4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 450, 0));
`endif

        // Reset state.
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_re", int'(re), 0);
        check("rst_im", int'(im), 0);
        check("rst_mul_a", int'(mul_a), 0);
        check("rst_mul_b", int'(mul_b), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic product with multiplier operand sequence; inputs scrambled after capture.
        send(mk(4'd3, 4'd2, 4'd5, 4'd4, 1'b0, 7, 22), 1'b0);
        ar = 4'd9; ai = 4'd1; br = 4'd14; bi = 4'd6;
        check("p0_mul_a", int'(mul_a), 3); check("p0_mul_b", int'(mul_b), 5);
        @(posedge clk); #1;
        check("p1_mul_a", int'(mul_a), 2); check("p1_mul_b", int'(mul_b), 4);
        check("busy_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        check("p2_mul_a", int'(mul_a), 3); check("p2_mul_b", int'(mul_b), 4);
        @(posedge clk); #1;
        check("p3_mul_a", int'(mul_a), 2); check("p3_mul_b", int'(mul_b), 5);
        @(posedge clk); #1;
        check("done_out_valid", int'(out_valid), 1);
        check("done_mul_a", int'(mul_a), 0);
        @(posedge clk); #1;
        check("idle_out_valid", int'(out_valid), 0);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_hold_re", int'($signed(re)), 7);
        check("idle_hold_im", int'($signed(im)), 22);

        // Table vectors back-to-back with in_valid held high.
        for (int i = 0; i < vecs.size(); i++) send(vecs[i], i < vecs.size() - 1);
        wait_out();
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Output stall in DONE for 7 cycles.
        out_ready = 1'b0;
        send(mk(4'd7, 4'd9, 4'd4, 4'd11, 1'b0, -71, 113), 1'b0);
        wait_out();
        @(posedge clk); #1;
        in_valid = 1'b1; ar = 4'd1; ai = 4'd1; br = 4'd1; bi = 4'd1;
        repeat (7) begin
            check("stall_out_valid", int'(out_valid), 1);
            check("stall_in_ready", int'(in_ready), 0);
            check("stall_re", int'($signed(re)), -71);
            check("stall_im", int'($signed(im)), 113);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_single_xfer", int'(out_valid), 0);

        // Asynchronous reset during P2; partial result discarded.
        send(mk(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 0, 450), 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", int'(out_valid), 0);
        check("arst_re", int'(re), 0);
        check("arst_im", int'(im), 0);
        check("arst_in_ready", int'(in_ready), 1);
        check("arst_mul_a", int'(mul_a), 0);
        exp_re_q.delete();
        exp_im_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(mk(4'd0, 4'd15, 4'd0, 4'd15, 1'b0, -225, 0), 1'b0);
        wait_out();
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("sb_empty", exp_re_q.size(), 0);
        check("result_count", n_results, vecs.size() + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
